// File: rtl/soc_timer_pkg.sv
// Shared types and constants for the prescaled timer/counter.
// FSM encoding and the one-shot/continuous mode values live here.
package soc_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/soc_timer_prescaler.sv
// Tick divider: one tick every presc+1 enabled cycles.
// Lowering presc below the count lets it wrap around naturally.
module soc_timer_prescaler #(
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clear,
  input  logic [PRESC_WIDTH-1:0] presc,
  output logic                   tick
);

  logic [PRESC_WIDTH-1:0] cnt;
  logic                   hit;

  assign hit  = (cnt == presc);
  assign tick = en && !clear && hit;

  // Count enabled cycles, restarting at zero on each tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= hit ? '0 : cnt + PRESC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/soc_timer_counter_presc.sv
// Prescaled timer with compare match, auto-reload or one-shot.
// Counting happens whenever enabled outside DONE; RUN follows a cycle later.
module soc_timer_counter_presc
  import soc_timer_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   clear_i,
  input  logic                   oneshot_i,
  input  logic [PRESC_WIDTH-1:0] prescaler_i,
  input  logic [CNT_WIDTH-1:0]   compare_i,
  output logic [CNT_WIDTH-1:0]   counter_o,
  output logic                   target_reached_o,
  output logic                   running_o,
  output logic                   done_o
);

  state_t state;
  state_t state_nxt;
  logic   active;
  logic   tick;
  logic   match_tick;

  assign active     = enable_i && !clear_i && (state != DONE);
  assign match_tick = tick && (counter_o == compare_i);
  assign running_o  = (state == RUN);
  assign done_o     = (state == DONE);

  soc_timer_prescaler #(
    .PRESC_WIDTH(PRESC_WIDTH)
  ) u_presc (
    .clk  (clk_i),
    .rst  (rst_i),
    .en   (active),
    .clear(clear_i),
    .presc(prescaler_i),
    .tick (tick)
  );

  // Main count: step on tick, reload or hold on match.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      counter_o <= '0;
    end else if (clear_i) begin
      counter_o <= '0;
    end else if (tick) begin
      if (match_tick) begin
        if (oneshot_i == MODE_CONT) begin
          counter_o <= '0;
        end
      end else begin
        counter_o <= counter_o + CNT_WIDTH'(1);
      end
    end
  end

  // One-cycle match pulse; a tick never occurs in a clear cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      target_reached_o <= 1'b0;
    end else begin
      target_reached_o <= match_tick;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; clear dominates everything except reset.
  always_comb begin
    state_nxt = state;
    if (clear_i) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable_i) begin
            state_nxt = (match_tick && oneshot_i == MODE_ONESHOT)
                      ? DONE : RUN;
          end
        end
        RUN: begin
          if (!enable_i) begin
            state_nxt = IDLE;
          end else if (match_tick && oneshot_i == MODE_ONESHOT) begin
            state_nxt = DONE;
          end
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_timer_counter_presc.sv
// Directed bench for the prescaled timer (4-bit count, 3-bit prescaler).
// Vector table for the steady-state modes, hand sequences for corners.
module tb_soc_timer_counter_presc;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic       os;
  logic [2:0] presc;
  logic [3:0] cmp;
  logic [3:0] cnt;
  logic       tr;
  logic       run;
  logic       done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       en;
    logic       clr;
    logic       os;
    logic [2:0] presc;
    logic [3:0] cmp;
    logic [3:0] cnt;
    logic       tr;
    logic       run;
    logic       done;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  soc_timer_counter_presc #(
    .CNT_WIDTH  (4),
    .PRESC_WIDTH(3)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .enable_i        (en),
    .clear_i         (clr),
    .oneshot_i       (os),
    .prescaler_i     (presc),
    .compare_i       (cmp),
    .counter_o       (cnt),
    .target_reached_o(tr),
    .running_o       (run),
    .done_o          (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic c, input logic o,
                       input logic [2:0] p, input logic [3:0] k);
    en = e; clr = c; os = o; presc = p; cmp = k;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int c, input int t,
                           input int r, input int d);
    check({tag, " cnt"}, int'(cnt), c);
    check({tag, " pulse"}, int'(tr), t);
    check({tag, " run"}, int'(run), r);
    check({tag, " done"}, int'(done), d);
  endtask

  task automatic add(input logic e, input logic c, input logic o,
                     input logic [2:0] p, input logic [3:0] k,
                     input logic [3:0] n, input logic t,
                     input logic r, input logic d);
    vec_t v;
    v.en = e; v.clr = c; v.os = o; v.presc = p; v.cmp = k;
    v.cnt = n; v.tr = t; v.run = r; v.done = d;
    tbl.push_back(v);
  endtask

  initial begin
    int exp_w[9];
    int exp_p[9];

    // Continuous, prescaler 0, compare 3: 1,2,3,0 with pulse on 0.
    for (int i = 0; i < 8; i++) begin
      add(1, 0, 0, 0, 3, 4'((i + 1) % 4), ((i % 4) == 3), 1, 0);
    end
    add(0, 1, 0, 0, 3, 0, 0, 0, 0);
    // Continuous, prescaler 2, compare 1: step every 3, pulse every 6.
    for (int i = 0; i < 12; i++) begin
      add(1, 0, 0, 2, 1, 4'(((i + 1) / 3) % 2), ((i % 6) == 5), 1, 0);
    end
    add(0, 1, 0, 2, 1, 0, 0, 0, 0);
    // One-shot, compare 5: single pulse, hold 5, DONE ignores enable.
    for (int i = 0; i < 5; i++) begin
      add(1, 0, 1, 0, 5, 4'(i + 1), 0, 1, 0);
    end
    add(1, 0, 1, 0, 5, 5, 1, 0, 1);
    add(1, 0, 1, 0, 5, 5, 0, 0, 1);
    add(0, 0, 1, 0, 5, 5, 0, 0, 1);
    add(1, 0, 1, 0, 5, 5, 0, 0, 1);
    add(1, 1, 1, 0, 5, 0, 0, 0, 0);
    add(0, 0, 1, 0, 5, 0, 0, 0, 0);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    step();
    check_all("reset", 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].os, tbl[i].presc, tbl[i].cmp);
      step();
      check_all($sformatf("vec%0d", i), int'(tbl[i].cnt), int'(tbl[i].tr),
                int'(tbl[i].run), int'(tbl[i].done));
    end

    // Compare lowered below the count: wrap through 15 to match on 2.
    drive(0, 1, 0, 0, 15);
    step();
    drive(1, 0, 0, 0, 15);
    for (int i = 0; i < 15; i++) step();
    check_all("max", 15, 0, 1, 0);
    step();
    check_all("max match", 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) step();
    check("at10 cnt", int'(cnt), 10);
    cmp = 4'd2;
    exp_w = '{11, 12, 13, 14, 15, 0, 1, 2, 0};
    exp_p = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("wrap%0d cnt", i), int'(cnt), exp_w[i]);
      check($sformatf("wrap%0d pulse", i), int'(tr), exp_p[i]);
    end

    // Pause at 7 mid prescaler period; resume keeps the phase.
    drive(0, 1, 0, 1, 15);
    step();
    drive(1, 0, 0, 1, 15);
    for (int i = 0; i < 15; i++) step();
    check_all("pre-pause", 7, 0, 1, 0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_all($sformatf("pause%0d", i), 7, 0, 0, 0);
    end
    en = 1'b1;
    step();
    check_all("resume", 8, 0, 1, 0);

    // Prescaler lowered below its count wraps at 8.
    drive(0, 1, 0, 5, 15);
    step();
    drive(1, 0, 0, 5, 15);
    for (int i = 0; i < 4; i++) step();
    presc = 3'd1;
    for (int i = 0; i < 5; i++) step();
    check("pwrap hold", int'(cnt), 0);
    step();
    check("pwrap tick", int'(cnt), 1);

    // Reset mid-count.
    drive(0, 1, 0, 0, 15);
    step();
    drive(1, 0, 0, 0, 15);
    for (int i = 0; i < 5; i++) step();
    check("pre-rst cnt", int'(cnt), 5);
    rst = 1'b1;
    clr = 1'b1;
    step();
    check_all("rst mid", 0, 0, 0, 0);
    rst = 1'b0;
    clr = 1'b0;
    step();
    check_all("after rst", 1, 0, 1, 0);

    // Reset while DONE.
    drive(0, 1, 1, 0, 2);
    step();
    drive(1, 0, 1, 0, 2);
    for (int i = 0; i < 3; i++) step();
    check_all("os done", 2, 1, 0, 1);
    rst = 1'b1;
    step();
    check_all("rst done", 0, 0, 0, 0);
    rst = 1'b0;

    // Clear on the match tick: no pulse now or later.
    drive(0, 1, 0, 0, 3);
    step();
    drive(1, 0, 0, 0, 3);
    for (int i = 0; i < 3; i++) step();
    check("pre-clr cnt", int'(cnt), 3);
    clr = 1'b1;
    step();
    check_all("clr match", 0, 0, 0, 0);
    clr = 1'b0;
    step();
    check_all("after clr", 1, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/soc_timer_counter_presc.md
SOC_TIMER_COUNTER_PRESC -- requirements
Module: soc_timer_counter_presc

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 32, counter and compare width (range 2..64).
REQ-002 The block SHALL have parameter PRESC_WIDTH, default 8, prescaler width (range 1..16).
REQ-003 The block SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port enable_i  input  1  run when high, pause when low.
REQ-006 The block SHALL have port clear_i  input  1  synchronous clear of counter, prescaler and state.
REQ-007 The block SHALL have port oneshot_i  input  1  0 = continuous auto-reload, 1 = one-shot.
REQ-008 The block SHALL have port prescaler_i  input  PRESC_WIDTH  tick divider; tick every prescaler_i+1 enabled cycles.
REQ-009 The block SHALL have port compare_i  input  CNT_WIDTH  terminal count.
REQ-010 The block SHALL have port counter_o  output  CNT_WIDTH  registered count value.
REQ-011 The block SHALL have port target_reached_o  output  1  registered one-cycle pulse per match.
REQ-012 The block SHALL have port running_o  output  1  high in state RUN.
REQ-013 The block SHALL have port done_o  output  1  high in state DONE (one-shot expired).

Function
REQ-014 The block SHALL implement states IDLE, RUN, DONE: IDLE->RUN when enable_i=1; RUN->IDLE when enable_i=0; RUN->DONE on match with oneshot_i=1; DONE->IDLE only on clear_i.
REQ-015 The prescaler counter SHALL increment each RUN cycle, and when it equals prescaler_i it SHALL return to 0 and generate an internal tick in that cycle.
REQ-016 prescaler_i=0 SHALL produce a tick every RUN cycle.
REQ-017 On a tick with counter_o != compare_i the counter SHALL increment by 1 modulo 2^CNT_WIDTH (max wraps to 0, no pulse).
REQ-018 On a tick with counter_o == compare_i the block SHALL assert target_reached_o in the next cycle for exactly one cycle.
REQ-019 On such a match in continuous mode, the counter SHALL load 0; continuous period SHALL be (compare_i+1)*(prescaler_i+1) cycles.
REQ-020 On such a match in one-shot mode, the counter SHALL hold compare_i and the state SHALL move to DONE; no further ticks or pulses until clear_i.
REQ-021 In IDLE and DONE, counter and prescaler SHALL hold their values (pause, not clear).
REQ-022 clear_i SHALL zero counter and prescaler and force state IDLE next cycle, taking priority over tick, match and enable_i; no pulse is generated in a clear cycle.
REQ-023 clear_i and enable_i both high SHALL leave the block in IDLE with count 0; counting starts the first cycle enable_i is high with clear_i low, RUN entered one cycle later.
REQ-024 compare_i lowered below counter_o while running SHALL let the counter run to wrap-around and match on the next pass.
REQ-025 prescaler_i lowered below the current prescaler count SHALL likewise wrap the prescaler at 2^PRESC_WIDTH.
REQ-026 oneshot_i and compare_i SHALL be sampled on the match tick only; changes at other times SHALL have no other effect.

Reset
REQ-027 When rst_i is high at a clock edge, state SHALL be IDLE, and counter_o, prescaler count, target_reached_o, running_o and done_o SHALL be 0 in the following cycle.
REQ-028 rst_i SHALL override clear_i and enable_i, including mid-count and in DONE.

Structure
REQ-029 Package soc_timer_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the mode constants MODE_CONT/MODE_ONESHOT.
REQ-030 The prescaler SHALL be the sub-module soc_timer_prescaler (inputs en, clear, prescaler value; output tick); everything else SHALL be in the top module.

Verification
REQ-031 prescaler_i=0, compare_i=3, continuous, enable held -> counter_o 0,1,2,3,0; target_reached_o pulses every 4 cycles.
REQ-032 prescaler_i=2, compare_i=1, continuous -> counter_o steps every 3 cycles; pulse period 6 cycles.
REQ-033 oneshot_i=1, compare_i=5, prescaler_i=0 -> single pulse, counter_o holds 5, done_o=1; enable toggling has no effect; clear_i -> counter_o=0, IDLE.
REQ-034 CNT_WIDTH=4, compare_i=15 reached, then compare_i set to 2 at count 10 -> counter runs 11..15,0,1,2, pulse on 2, reload 0.
REQ-035 enable_i dropped at count 7 for 5 cycles -> counter_o stays 7, running_o=0; resumes at 8 with prescaler phase preserved.
REQ-036 rst_i pulsed mid-count, and clear_i coincident with a match tick -> all outputs 0 next cycle, no target_reached_o pulse.
